// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider
// sharing one iteration counter; fixed XLEN+2 cycle latency from accept to done.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, mc_q, mc_d;
    logic [XLEN-1:0]   a_raw_q, a_raw_d, result_q, result_d;
    logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic              busy_q, busy_d, done_q, done_d;

    logic              is_div_in, sgn_a_in, sgn_b_in, neg_a_in, neg_b_in;
    logic [XLEN-1:0]   mag_a_in, mag_b_in;
    logic [XLEN:0]     add_sum, rem_shift;
    logic [XLEN-1:0]   diff;
    logic              rem_ge;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   q_fix, r_fix;

    always_comb begin
        is_div_in = funct3[2];
        sgn_a_in  = is_div_in ? !funct3[0] : (funct3[1:0] != 2'b11);
        sgn_b_in  = is_div_in ? !funct3[0] : !funct3[1];
        neg_a_in  = sgn_a_in & op_a[XLEN-1];
        neg_b_in  = sgn_b_in & op_b[XLEN-1];
        mag_a_in  = neg_a_in ? -op_a : op_a;
        mag_b_in  = neg_b_in ? -op_b : op_b;

        // hi_q is the running product high half (multiply) or partial remainder (divide)
        add_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mc_q} : '0);
        rem_shift = {hi_q, lo_q[XLEN-1]};
        rem_ge    = rem_shift >= {1'b0, mc_q};
        diff      = rem_shift[XLEN-1:0] - mc_q;

        prod_fix  = (neg_a_q ^ neg_b_q) ? -{hi_q, lo_q} : {hi_q, lo_q};
        q_fix     = (neg_a_q ^ neg_b_q) ? -lo_q : lo_q;
        r_fix     = neg_a_q ? -hi_q : hi_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mc_d     = mc_q;
        a_raw_d  = a_raw_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        result_d = result_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d = S_CALC;
                    cnt_d   = '0;
                    f3_d    = funct3;
                    a_raw_d = op_a;
                    neg_a_d = neg_a_in;
                    neg_b_d = neg_b_in;
                    hi_d    = '0;
                    lo_d    = is_div_in ? mag_a_in : mag_b_in;
                    mc_d    = is_div_in ? mag_b_in : mag_a_in;
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (f3_q[2]) begin
                    hi_d = rem_ge ? diff : rem_shift[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], rem_ge};
                end else begin
                    hi_d = add_sum[XLEN:1];
                    lo_d = {add_sum[0], lo_q[XLEN-1:1]};
                end
                if (cnt_q == CW'(XLEN - 1)) begin
                    state_d = S_FIX;
                    cnt_d   = '0;
                end
            end
            S_FIX: begin
                state_d = S_DONE;
                done_d  = 1'b1;
                // Most-negative / -1 falls out of the magnitude path: 2^(XLEN-1)/1, remainder 0
                if (f3_q[2]) begin
                    if (mc_q == '0)
                        result_d = f3_q[1] ? a_raw_q : '1;
                    else
                        result_d = f3_q[1] ? r_fix : q_fix;
                end else begin
                    result_d = (f3_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0]
                                                    : prod_fix[2*XLEN-1:XLEN];
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_CALC) || (state_d == S_FIX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            mc_q     <= '0;
            a_raw_q  <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            mc_q     <= mc_d;
            a_raw_q  <= a_raw_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
endmodule
